// File: rtl/otter_pkg.sv
// Shared RV32M multiply/divide types: funct3 codes, FSM states, iteration count.
// Functions decode which operands of a funct3 are treated as signed.
package otter_pkg;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_fun_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    CORE_MUL = 1'b0,
    CORE_DIV = 1'b1
  } core_mode_t;

  function automatic logic fun_is_div(input md_fun_t f);
    return f[2];
  endfunction

  function automatic logic fun_a_signed(input md_fun_t f);
    return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic fun_b_signed(input md_fun_t f);
    return f inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/otter_muldiv_core.sv
// Radix-2 step engine on unsigned magnitudes: shift-add multiply or restoring divide.
// One step per enabled cycle; res_hi/res_lo present the result of the step about to be taken.
module otter_muldiv_core
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  core_mode_t      mode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN:0]   op_b,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic [XLEN:0]   hi_q, dvs_q, hi_nxt, trial;
  logic [XLEN-1:0] lo_q, lo_nxt;
  logic [XLEN+1:0] sum, diff;

  // mul: {hi,lo} is partial product, lo holds remaining multiplier bits.
  // div: hi is partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, dvs_q};
    trial  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    diff   = {1'b0, trial} - {1'b0, dvs_q};
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (mode == CORE_MUL) begin
      if (lo_q[0]) begin
        hi_nxt = sum[XLEN+1:1];
        lo_nxt = {sum[0], lo_q[XLEN-1:1]};
      end else begin
        hi_nxt = {1'b0, hi_q[XLEN:1]};
        lo_nxt = {hi_q[0], lo_q[XLEN-1:1]};
      end
    end else if (!diff[XLEN+1]) begin
      hi_nxt = diff[XLEN:0];
      lo_nxt = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt = trial;
      lo_nxt = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= op_a;
      dvs_q <= op_b;
    end else if (en) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  assign res_hi = hi_nxt[XLEN-1:0];
  assign res_lo = lo_nxt;

endmodule

// File: rtl/otter_muldiv.sv
// RV32M mul/div: MD_DONE 33 cycles after MD_START (2 for div-by-zero/overflow, and for MUL* with OTTER_MULDIV_FAST_MUL_EN).
// No backpressure: MD_BUSY stalls the pipeline, MD_START is taken only in IDLE, MD_FLUSH aborts.
module otter_muldiv
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MD_START,
  input  logic            MD_FLUSH,
  input  logic [XLEN-1:0] MD_a,
  input  logic [XLEN-1:0] MD_b,
  input  logic [2:0]      MD_FUN,
  output logic            MD_BUSY,
  output logic            MD_DONE,
  output logic [XLEN-1:0] MD_RESULT
);

  md_state_t             state, state_nxt;
  md_fun_t               fun_in, fun_q;
  logic [MD_CNT_W-1:0]   cnt;
  logic [XLEN-1:0]       a_q, b_q, mag_a_in, mag_b_in, core_hi, core_lo, quo, rem_v, res_val;
  logic [2*XLEN-1:0]     prod;
  logic                  capture, neg_a, neg_b, div_zero, div_ovf, fast_mul, last, res_ld;

  assign fun_in   = md_fun_t'(MD_FUN);
  assign capture  = (state == IDLE) && MD_START && !MD_FLUSH;
  assign mag_a_in = (fun_a_signed(fun_in) && MD_a[XLEN-1]) ? -MD_a : MD_a;
  assign mag_b_in = (fun_b_signed(fun_in) && MD_b[XLEN-1]) ? -MD_b : MD_b;

  otter_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (CLK),
    .rst    (RST),
    .load   (capture),
    .en     (state == CALC),
    .mode   (fun_is_div(fun_q) ? CORE_DIV : CORE_MUL),
    .op_a   (mag_a_in),
    .op_b   ({1'b0, mag_b_in}),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  assign neg_a    = fun_a_signed(fun_q) && a_q[XLEN-1];
  assign neg_b    = fun_b_signed(fun_q) && b_q[XLEN-1];
  assign div_zero = fun_is_div(fun_q) && (b_q == '0);
  assign div_ovf  = ((fun_q == MD_DIV) || (fun_q == MD_REM)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign last     = (cnt == MD_CNT_W'(MD_ITERS - 1));
`ifdef OTTER_MULDIV_FAST_MUL_EN
  assign fast_mul = !fun_is_div(fun_q);
`else
  assign fast_mul = 1'b0;
`endif

  always_comb begin
`ifdef OTTER_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fa_w, fb_w;
    fa   = {fun_a_signed(fun_q) && a_q[XLEN-1], a_q};
    fb   = {fun_b_signed(fun_q) && b_q[XLEN-1], b_q};
    fa_w = (2*XLEN)'(fa);
    fb_w = (2*XLEN)'(fb);
    prod = fa_w * fb_w;
`else
    prod = {core_hi, core_lo};
    if (neg_a ^ neg_b) prod = -prod;
`endif
    quo   = (neg_a ^ neg_b) ? -core_lo : core_lo;
    rem_v = neg_a ? -core_hi : core_hi;
    case (fun_q)
      MD_MUL:                       res_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_val = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_val = quo;
      default:                      res_val = rem_v;
    endcase
    // fun_q[1] separates REM/REMU from DIV/DIVU
    if (div_zero)     res_val = fun_q[1] ? a_q : '1;
    else if (div_ovf) res_val = fun_q[1] ? '0 : a_q;
  end

  always_comb begin
    state_nxt = state;
    res_ld    = 1'b0;
    case (state)
      IDLE: if (capture) state_nxt = CALC;
      CALC: if (div_zero || div_ovf || fast_mul || last) begin
        state_nxt = DONE;
        res_ld    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (MD_FLUSH) begin
      state_nxt = IDLE;
      res_ld    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= MD_MUL;
      MD_RESULT <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        a_q   <= MD_a;
        b_q   <= MD_b;
        fun_q <= fun_in;
        cnt   <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
      if (res_ld) MD_RESULT <= res_val;
    end
  end

  assign MD_BUSY = (state == CALC);
  assign MD_DONE = (state == DONE);

endmodule

// File: tb/tb_otter_muldiv.sv
// Directed-vector bench for otter_muldiv: results, latency, busy/done shape, flush and reset.
module tb_otter_muldiv;
  import otter_pkg::*;

`ifdef OTTER_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MD_START = 1'b0;
  logic        MD_FLUSH = 1'b0;
  logic [31:0] MD_a = '0;
  logic [31:0] MD_b = '0;
  logic [2:0]  MD_FUN = '0;
  logic        MD_BUSY, MD_DONE;
  logic [31:0] MD_RESULT;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res = '0;

  otter_muldiv #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MD_START  (MD_START),
    .MD_FLUSH  (MD_FLUSH),
    .MD_a      (MD_a),
    .MD_b      (MD_b),
    .MD_FUN    (MD_FUN),
    .MD_BUSY   (MD_BUSY),
    .MD_DONE   (MD_DONE),
    .MD_RESULT (MD_RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Starts one op, pokes MD_START mid-CALC and at DONE (both must be ignored),
  // then checks latency, result, busy shape and the one-cycle DONE pulse.
  task automatic run_op(input string tag, input logic [2:0] fun, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   cyc;
    logic busy_bad;
    MD_FUN = fun; MD_a = a; MD_b = b; MD_START = 1'b1;
    tick;
    MD_START = 1'b0;
    cyc = 1;
    busy_bad = 1'b0;
    while (!MD_DONE && cyc < 60) begin
      if (!MD_BUSY) busy_bad = 1'b1;
      if (cyc == 5) begin
        MD_START = 1'b1; MD_FUN = MD_DIVU; MD_a = '0; MD_b = '0;
      end else begin
        MD_START = 1'b0;
      end
      tick;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_res"}, MD_RESULT, exp);
    chk({tag, "_busy"}, {31'd0, busy_bad | MD_BUSY}, 32'd0);
    MD_START = 1'b1; MD_FUN = MD_DIVU; MD_a = 32'd9; MD_b = '0;
    tick;
    MD_START = 1'b0;
    chk({tag, "_after"}, {30'd0, MD_BUSY, MD_DONE}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    #3;
    chk("rst_busy", {31'd0, MD_BUSY}, 32'd0);
    chk("rst_done", {31'd0, MD_DONE}, 32'd0);
    chk("rst_res", MD_RESULT, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    tick;

    run_op("mul",     MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh",    MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulhu",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu",  MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
    run_op("mulh_m1", MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
    run_op("div",     MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    run_op("rem",     MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    run_op("div_nb",  MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
    run_op("rem_nb",  MD_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT);
    run_op("divu",    MD_DIVU,   32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, DIV_LAT);
    run_op("remu",    MD_REMU,   32'd100,      32'd7,        32'h00000002, DIV_LAT);
    run_op("divu_z",  MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
    run_op("rem_z",   MD_REM,    32'h1234,     32'd0,        32'h00001234, SPC_LAT);
    run_op("div_ovf", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
    run_op("rem_ovf", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT);
    run_op("mulhu_s", MD_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, MUL_LAT);

    // Flush a DIV at cycle +10: no DONE, result keeps its previous value
    MD_FUN = MD_DIV; MD_a = 32'd100; MD_b = 32'd7; MD_START = 1'b1;
    tick;
    MD_START = 1'b0;
    repeat (9) tick;
    chk("flush_busy_before", {31'd0, MD_BUSY}, 32'd1);
    MD_FLUSH = 1'b1;
    tick;
    MD_FLUSH = 1'b0;
    chk("flush_idle", {30'd0, MD_BUSY, MD_DONE}, 32'd0);
    saw_done = 1'b0;
    repeat (35) begin
      tick;
      if (MD_DONE) saw_done = 1'b1;
    end
    chk("flush_no_done", {31'd0, saw_done}, 32'd0);
    chk("flush_res_kept", MD_RESULT, last_res);

    // Start together with flush in IDLE is not accepted
    MD_FUN = MD_DIVU; MD_a = 32'd5; MD_b = 32'd0; MD_START = 1'b1; MD_FLUSH = 1'b1;
    tick;
    MD_START = 1'b0; MD_FLUSH = 1'b0;
    chk("flush_start_busy", {31'd0, MD_BUSY}, 32'd0);
    tick;
    chk("flush_start_done", {31'd0, MD_DONE}, 32'd0);
    chk("flush_start_res", MD_RESULT, last_res);

    // Reset pulse at cycle +5 of a MUL clears everything asynchronously
    MD_FUN = MD_MUL; MD_a = 32'd7; MD_b = 32'hFFFFFFFD; MD_START = 1'b1;
    tick;
    MD_START = 1'b0;
    repeat (4) tick;
    #1 RST = 1'b1;
    #1;
    chk("arst_busy", {31'd0, MD_BUSY}, 32'd0);
    chk("arst_done", {31'd0, MD_DONE}, 32'd0);
    chk("arst_res", MD_RESULT, 32'd0);
    #1 RST = 1'b0;
    run_op("divu_rst", MD_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
